// File: rtl/ifmap_pkg.sv
// Shared definitions for the ifmap stream loader: opcodes, status bit map,
// FSM state types and the one-hot kernel-size decode.
package ifmap_pkg;

    localparam logic [7:0] INST_COMPUTE    = 8'd87;
    localparam logic [7:0] INST_LOADIFMAPS = 8'd88;

    localparam int unsigned ST_LOAD_BUSY    = 0;
    localparam int unsigned ST_LOAD_DONE    = 1;
    localparam int unsigned ST_COMP_BUSY    = 2;
    localparam int unsigned ST_COMP_DONE    = 3;
    localparam int unsigned ST_ERR_TLAST    = 4;
    localparam int unsigned ST_ERR_CFG      = 5;
    localparam int unsigned ST_ERR_CMD      = 6;
    localparam int unsigned ST_ACTIVE_BANK  = 7;
    localparam int unsigned ST_WORDS_LSB    = 16;
    localparam int unsigned WORD_CNT_WIDTH  = 15;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_LOAD,
        LD_DONE
    } load_state_t;

    typedef enum logic {
        CP_IDLE,
        CP_RUN
    } comp_state_t;

    // Anything that is not exactly one-hot falls back to the largest kernel.
    function automatic logic [2:0] kernel_decode(input logic [4:0] onehot);
        logic [2:0] k;
        case (onehot)
            5'b00001: k = 3'd1;
            5'b00010: k = 3'd2;
            5'b00100: k = 3'd3;
            5'b01000: k = 3'd4;
            5'b10000: k = 3'd5;
            default:  k = 3'd5;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/ifmap_stream_loader_cmd_edge_decode.sv
// Turns a level-held AXI-Lite opcode into single-cycle command pulses by
// comparing against the previous cycle's value.
module cmd_edge_decode
    import ifmap_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] opcode,
    output logic       load_cmd,
    output logic       compute_cmd
);

    logic [7:0] prev_opcode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_opcode <= '0;
        end else begin
            prev_opcode <= opcode;
        end
    end

    always_comb begin
        load_cmd    = (opcode != prev_opcode) && (opcode == INST_LOADIFMAPS);
        compute_cmd = (opcode != prev_opcode) && (opcode == INST_COMPUTE);
    end

endmodule

// File: rtl/ifmap_stream_loader.sv
// Ifmap ingest front end: decodes load/compute commands, streams ch*k words
// into BRAM and tracks compute. Define IFMAP_PINGPONG_EN for two-bank operation.
module ifmap_stream_loader
    import ifmap_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int BRAM_ADDRESS_WIDTH   = 12,
    parameter int CH_WIDTH             = 12,
    parameter int MAX_KERNEL           = 5
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                            S_AXIS_TLAST,
    input  logic                            S_AXIS_TVALID,
    output logic                            S_AXIS_TREADY,
    input  logic [7:0]                      ctrl_opcode,
    input  logic [CH_WIDTH-1:0]             ctrl_in_channels,
    input  logic [MAX_KERNEL-1:0]           ctrl_kernel_onehot,
    output logic                            bram_we,
    output logic [BRAM_ADDRESS_WIDTH-1:0]   bram_addr,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0] bram_wdata,
    output logic [2:0]                      kernel_size,
    output logic [CH_WIDTH-1:0]             in_channels,
    output logic                            compute_start,
    input  logic                            compute_done,
    output logic [31:0]                     status
);

`ifdef IFMAP_PINGPONG_EN
    localparam int unsigned BANK_CAP = 32'd1 << (BRAM_ADDRESS_WIDTH - 1);
`else
    localparam int unsigned BANK_CAP = 32'd1 << BRAM_ADDRESS_WIDTH;
`endif

    logic                          load_cmd;
    logic                          compute_cmd;
    load_state_t                   ld_state;
    load_state_t                   ld_next;
    comp_state_t                   cp_state;
    comp_state_t                   cp_next;
    logic [WORD_CNT_WIDTH-1:0]     count;
    logic [WORD_CNT_WIDTH-1:0]     expected;
    logic [WORD_CNT_WIDTH-1:0]     req_expected;
    logic [2:0]                    k_dec;
    logic                          handshake;
    logic                          last_word;
    logic                          cfg_bad;
    logic                          load_blocked;
    logic                          load_eligible;
    logic                          load_accept;
    logic                          compute_accept;
    logic                          err_tlast;
    logic                          err_cfg;
    logic                          err_cmd;
    logic                          done_flag;
    logic [BRAM_ADDRESS_WIDTH-1:0] base_addr;
    logic                          bank_bit;

    cmd_edge_decode u_cmd_edge_decode (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (ctrl_opcode),
        .load_cmd    (load_cmd),
        .compute_cmd (compute_cmd)
    );

`ifdef IFMAP_PINGPONG_EN
    logic fill_bank;
    logic active_bank;
    logic run_bank;
    logic bank_valid;
    logic next_bank;

    // Fill the bank compute is not reading; the first ever load goes to bank 0.
    always_comb begin
        if (cp_state == CP_RUN) begin
            next_bank = ~run_bank;
        end else if (bank_valid) begin
            next_bank = ~active_bank;
        end else begin
            next_bank = 1'b0;
        end
        load_blocked = 1'b0;
        base_addr    = {fill_bank, {(BRAM_ADDRESS_WIDTH-1){1'b0}}};
        bank_bit     = active_bank;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_bank   <= 1'b0;
            active_bank <= 1'b0;
            run_bank    <= 1'b0;
            bank_valid  <= 1'b0;
        end else begin
            if (load_accept) begin
                fill_bank <= next_bank;
            end
            if (handshake && last_word) begin
                active_bank <= fill_bank;
                bank_valid  <= 1'b1;
            end
            if (compute_accept) begin
                run_bank <= active_bank;
            end
        end
    end
`else
    always_comb begin
        load_blocked = (cp_state == CP_RUN);
        base_addr    = '0;
        bank_bit     = 1'b0;
    end
`endif

    always_comb begin
        k_dec          = kernel_decode(5'(ctrl_kernel_onehot));
        req_expected   = WORD_CNT_WIDTH'(ctrl_in_channels) * WORD_CNT_WIDTH'(k_dec);
        cfg_bad        = (ctrl_in_channels == '0) || (32'(req_expected) > BANK_CAP);
        load_eligible  = load_cmd && !load_blocked && (ld_state != LD_LOAD);
        load_accept    = load_eligible && !cfg_bad;
        compute_accept = compute_cmd && (ld_state == LD_DONE) && (cp_state == CP_IDLE);
        handshake      = (ld_state == LD_LOAD) && S_AXIS_TREADY && S_AXIS_TVALID;
        last_word      = (count == expected - 1'b1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_state <= LD_IDLE;
        end else begin
            ld_state <= ld_next;
        end
    end

    always_comb begin
        ld_next = ld_state;
        case (ld_state)
            LD_IDLE, LD_DONE: if (load_accept)            ld_next = LD_LOAD;
            LD_LOAD:          if (handshake && last_word) ld_next = LD_DONE;
            default:                                      ld_next = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cp_state <= CP_IDLE;
        end else begin
            cp_state <= cp_next;
        end
    end

    // A COMPUTE that coincides with compute_done is judged against RUN and rejected.
    always_comb begin
        cp_next = cp_state;
        case (cp_state)
            CP_IDLE: if (compute_accept) cp_next = CP_RUN;
            CP_RUN:  if (compute_done)   cp_next = CP_IDLE;
            default:                     cp_next = CP_IDLE;
        endcase
    end

    always_comb begin
        status                                    = '0;
        status[ST_LOAD_BUSY]                      = (ld_state == LD_LOAD);
        status[ST_LOAD_DONE]                      = (ld_state == LD_DONE);
        status[ST_COMP_BUSY]                      = (cp_state == CP_RUN);
        status[ST_COMP_DONE]                      = done_flag;
        status[ST_ERR_TLAST]                      = err_tlast;
        status[ST_ERR_CFG]                        = err_cfg;
        status[ST_ERR_CMD]                        = err_cmd;
        status[ST_ACTIVE_BANK]                    = bank_bit;
        status[ST_WORDS_LSB +: WORD_CNT_WIDTH]    = count;
    end

    // TREADY follows the next state so it falls on the final handshake edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S_AXIS_TREADY <= 1'b0;
            bram_we       <= 1'b0;
            bram_addr     <= '0;
            bram_wdata    <= '0;
            kernel_size   <= 3'd5;
            in_channels   <= '0;
            expected      <= '0;
            count         <= '0;
            compute_start <= 1'b0;
            err_tlast     <= 1'b0;
            err_cfg       <= 1'b0;
            err_cmd       <= 1'b0;
            done_flag     <= 1'b0;
        end else begin
            S_AXIS_TREADY <= (ld_next == LD_LOAD);
            bram_we       <= handshake;
            compute_start <= compute_accept;
            if (load_accept) begin
                in_channels <= ctrl_in_channels;
                kernel_size <= k_dec;
                expected    <= req_expected;
                count       <= '0;
                err_tlast   <= 1'b0;
                err_cfg     <= 1'b0;
                err_cmd     <= 1'b0;
            end
            if (handshake) begin
                bram_addr  <= base_addr + count[BRAM_ADDRESS_WIDTH-1:0];
                bram_wdata <= S_AXIS_TDATA;
                count      <= count + 1'b1;
                if (S_AXIS_TLAST != last_word) begin
                    err_tlast <= 1'b1;
                end
            end
            if (load_eligible && cfg_bad) begin
                err_cfg <= 1'b1;
            end
            if ((load_cmd && load_blocked) || (compute_cmd && !compute_accept)) begin
                err_cmd <= 1'b1;
            end
            if (compute_accept) begin
                done_flag <= 1'b0;
            end else if ((cp_state == CP_RUN) && compute_done) begin
                done_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ifmap_stream_loader.sv
// Directed + randomized bench for ifmap_stream_loader (single-bank build),
// checked against a transaction-level model of the command/load/compute rules.
module tb_ifmap_stream_loader;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int CW = 12;
    localparam int MK = 5;
    localparam logic [7:0] OP_COMPUTE = 8'd87;
    localparam logic [7:0] OP_LOAD    = 8'd88;
    localparam int CAPACITY = 4096;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] s_tdata;
    logic          s_tlast;
    logic          s_tvalid;
    logic          s_tready;
    logic [7:0]    ctrl_opcode;
    logic [CW-1:0] ctrl_in_channels;
    logic [MK-1:0] ctrl_kernel_onehot;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_wdata;
    logic [2:0]    kernel_size;
    logic [CW-1:0] in_channels;
    logic          compute_start;
    logic          compute_done;
    logic [31:0]   status;

    ifmap_stream_loader #(
        .C_S_AXIS_TDATA_WIDTH (DW),
        .BRAM_ADDRESS_WIDTH   (AW),
        .CH_WIDTH             (CW),
        .MAX_KERNEL           (MK)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .S_AXIS_TDATA       (s_tdata),
        .S_AXIS_TLAST       (s_tlast),
        .S_AXIS_TVALID      (s_tvalid),
        .S_AXIS_TREADY      (s_tready),
        .ctrl_opcode        (ctrl_opcode),
        .ctrl_in_channels   (ctrl_in_channels),
        .ctrl_kernel_onehot (ctrl_kernel_onehot),
        .bram_we            (bram_we),
        .bram_addr          (bram_addr),
        .bram_wdata         (bram_wdata),
        .kernel_size        (kernel_size),
        .in_channels        (in_channels),
        .compute_start      (compute_start),
        .compute_done       (compute_done),
        .status             (status)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          start_count = 0;
    logic [31:0] words [0:4095];

    always @(negedge clk) begin
        if (bram_we) begin
            wr_addr_q.push_back(32'(bram_addr));
            wr_data_q.push_back(bram_wdata);
        end
        if (compute_start) start_count++;
    end

    // Reference model state
    bit          m_busy, m_done, m_cbusy, m_cflag, m_etl, m_ecfg, m_ecmd;
    int          m_words, m_expect, m_ch, m_k;
    logic [31:0] exp_data_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int kdec(input logic [4:0] oh);
        if ($countones(oh) != 1) return 5;
        for (int i = 0; i < 5; i++) if (oh[i]) return i + 1;
        return 5;
    endfunction

    function automatic void model_reset();
        m_busy = 0; m_done = 0; m_cbusy = 0; m_cflag = 0;
        m_etl = 0; m_ecfg = 0; m_ecmd = 0;
        m_words = 0; m_expect = 0; m_ch = 0; m_k = 5;
        exp_data_q.delete();
    endfunction

    function automatic void model_load(input int ch, input logic [4:0] oh);
        int k = kdec(oh);
        if (m_cbusy) begin
            m_ecmd = 1;
        end else if (!m_busy) begin
            if (ch == 0 || ch * k > CAPACITY) begin
                m_ecfg = 1;
            end else begin
                m_busy = 1; m_done = 0; m_words = 0; m_expect = ch * k;
                m_ch = ch; m_k = k; m_etl = 0; m_ecfg = 0; m_ecmd = 0;
                exp_data_q.delete();
            end
        end
    endfunction

    function automatic void model_word(input logic [31:0] data, input bit last);
        if (!m_busy) return;
        exp_data_q.push_back(data);
        if (last != (m_words == m_expect - 1)) m_etl = 1;
        m_words++;
        if (m_words == m_expect) begin
            m_busy = 0;
            m_done = 1;
        end
    endfunction

    function automatic void model_compute(input bit done_same_cycle);
        bit was_running = m_cbusy;
        if (m_done && !was_running) begin
            m_cbusy = 1;
            m_cflag = 0;
        end else begin
            m_ecmd = 1;
        end
        if (done_same_cycle && was_running) begin
            m_cbusy = 0;
            m_cflag = 1;
        end
    endfunction

    function automatic logic [31:0] exp_status();
        return 32'(m_busy) + 32'(m_done) * 2 + 32'(m_cbusy) * 4 + 32'(m_cflag) * 8
             + 32'(m_etl) * 16 + 32'(m_ecfg) * 32 + 32'(m_ecmd) * 64
             + 32'(m_words) * 65536;
    endfunction

    task automatic send_cmd(input logic [7:0] op, input int ch, input logic [4:0] oh);
        @(negedge clk);
        ctrl_in_channels   = CW'(ch);
        ctrl_kernel_onehot = oh;
        ctrl_opcode        = op;
        @(negedge clk);
        ctrl_opcode = 8'd0;
    endtask

    task automatic stream(input int n, input bit toggle, input int last_idx,
                          input int budget, output int acc);
        int idx = 0;
        bit phase = 0;
        for (int c = 0; c < budget && idx < n; c++) begin
            @(negedge clk);
            phase    = !phase;
            s_tvalid = toggle ? phase : 1'b1;
            s_tdata  = words[idx];
            s_tlast  = (idx == last_idx);
            if (s_tvalid && s_tready) idx++;
        end
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        acc = idx;
    endtask

    task automatic do_load(input int ch, input logic [4:0] oh, input int n, input bit toggle,
                           input int last_idx, input int budget, input string tag);
        int acc;
        int exp_acc;
        int bad;
        wr_addr_q.delete();
        wr_data_q.delete();
        send_cmd(OP_LOAD, ch, oh);
        model_load(ch, oh);
        exp_acc = m_busy ? ((n < m_expect) ? n : m_expect) : 0;
        stream(n, toggle, last_idx, budget, acc);
        for (int i = 0; i < acc; i++) model_word(words[i], i == last_idx);
        repeat (2) @(negedge clk);
        check({tag, " accepted"}, 32'(acc), 32'(exp_acc));
        check({tag, " writes"}, 32'(wr_addr_q.size()), 32'(exp_acc));
        bad = 0;
        for (int i = 0; i < wr_addr_q.size() && i < exp_data_q.size(); i++)
            if (wr_addr_q[i] != 32'(i) || wr_data_q[i] != exp_data_q[i]) bad++;
        check({tag, " write content"}, 32'(bad), 32'd0);
        check({tag, " status"}, status, exp_status());
        check({tag, " tready"}, 32'(s_tready), 32'd0);
        check({tag, " kernel_size"}, 32'(kernel_size), 32'(m_k));
        check({tag, " in_channels"}, 32'(in_channels), 32'(m_ch));
    endtask

    initial begin
        int s0, acc, ch, n, last, highs;
        logic [4:0] oh;

        rst_n = 1'b0;
        s_tdata = '0; s_tlast = 1'b0; s_tvalid = 1'b0;
        ctrl_opcode = 8'd0; ctrl_in_channels = '0; ctrl_kernel_onehot = '0;
        compute_done = 1'b0;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst tready", 32'(s_tready), 32'd0);
        check("rst bram_we", 32'(bram_we), 32'd0);
        check("rst bram_addr", 32'(bram_addr), 32'd0);
        check("rst bram_wdata", bram_wdata, 32'd0);
        check("rst kernel_size", 32'(kernel_size), 32'd5);
        check("rst in_channels", 32'(in_channels), 32'd0);
        check("rst compute_start", 32'(compute_start), 32'd0);
        check("rst status", status, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // COMPUTE with nothing loaded
        s0 = start_count;
        send_cmd(OP_COMPUTE, 0, 5'b0);
        model_compute(0);
        repeat (2) @(negedge clk);
        check("early compute start", 32'(start_count - s0), 32'd0);
        check("early compute status", status, exp_status());

        // Fixed five-word burst, k=5
        words[0] = 32'h1F; words[1] = 32'h17; words[2] = 32'h1D;
        words[3] = 32'h1B; words[4] = 32'h11;
        do_load(1, 5'b10000, 5, 0, 4, 20, "load5");

        // Compute launch, interlock, simultaneous done+compute, normal finish
        s0 = start_count;
        send_cmd(OP_COMPUTE, 0, 5'b0);
        model_compute(0);
        repeat (2) @(negedge clk);
        check("compute start pulses", 32'(start_count - s0), 32'd1);
        check("compute run status", status, exp_status());
        send_cmd(OP_LOAD, 2, 5'b00010);
        model_load(2, 5'b00010);
        repeat (3) @(negedge clk);
        check("interlock status", status, exp_status());
        check("interlock tready", 32'(s_tready), 32'd0);
        check("interlock in_channels", 32'(in_channels), 32'(m_ch));
        @(negedge clk);
        ctrl_opcode = OP_COMPUTE; compute_done = 1'b1;
        @(negedge clk);
        ctrl_opcode = 8'd0; compute_done = 1'b0;
        model_compute(1);
        repeat (2) @(negedge clk);
        check("simul start pulses", 32'(start_count - s0), 32'd1);
        check("simul status", status, exp_status());
        send_cmd(OP_COMPUTE, 0, 5'b0);
        model_compute(0);
        repeat (2) @(negedge clk);
        check("recompute start pulses", 32'(start_count - s0), 32'd2);
        check("recompute status", status, exp_status());
        @(negedge clk); compute_done = 1'b1;
        @(negedge clk); compute_done = 1'b0;
        if (m_cbusy) begin m_cbusy = 0; m_cflag = 1; end
        @(negedge clk);
        check("compute done status", status, exp_status());

        // ch=3 k=3 with gapped TVALID and one extra word offered
        for (int i = 0; i < 10; i++) words[i] = $urandom;
        do_load(3, 5'b00100, 10, 1, 8, 60, "load9 gapped");

        // Early TLAST on the second of five words
        for (int i = 0; i < 5; i++) words[i] = $urandom;
        do_load(1, 5'b10000, 5, 0, 1, 20, "early tlast");

        // Randomized loads, including non-one-hot kernel fields
        for (int r = 0; r < 4; r++) begin
            ch = int'($urandom_range(1, 12));
            oh = 5'($urandom_range(0, 31));
            n  = ch * kdec(oh);
            last = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : n - 1;
            for (int i = 0; i < n; i++) words[i] = $urandom;
            do_load(ch, oh, n, 1'($urandom_range(0, 1)), last, 2 * n + 10, "random load");
        end

        // Configuration rejects leave the loader untouched
        send_cmd(OP_LOAD, 0, 5'b10000);
        model_load(0, 5'b10000);
        highs = 0;
        repeat (3) begin @(negedge clk); if (s_tready) highs++; end
        check("cfg ch0 status", status, exp_status());
        check("cfg ch0 tready", 32'(highs), 32'd0);
        check("cfg ch0 in_channels", 32'(in_channels), 32'(m_ch));
        send_cmd(OP_LOAD, 1000, 5'b10000);
        model_load(1000, 5'b10000);
        highs = 0;
        repeat (3) begin @(negedge clk); if (s_tready) highs++; end
        check("cfg 5000 status", status, exp_status());
        check("cfg 5000 tready", 32'(highs), 32'd0);
        check("cfg 5000 kernel_size", 32'(kernel_size), 32'(m_k));

        // Exactly bank capacity
        for (int i = 0; i < CAPACITY; i++) words[i] = $urandom;
        do_load(1024, 5'b01000, CAPACITY, 0, CAPACITY - 1, CAPACITY + 100, "full bank");

        // Reset in the middle of a burst
        for (int i = 0; i < 5; i++) words[i] = $urandom;
        send_cmd(OP_LOAD, 1, 5'b10000);
        model_load(1, 5'b10000);
        stream(2, 0, 4, 10, acc);
        for (int i = 0; i < acc; i++) model_word(words[i], i == 4);
        check("midload accepted", 32'(acc), 32'd2);
        check("midload tready", 32'(s_tready), 32'd1);
        check("midload status", status, exp_status());
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("async rst tready", 32'(s_tready), 32'd0);
        check("async rst status", status, exp_status());
        check("async rst bram_we", 32'(bram_we), 32'd0);
        check("async rst bram_addr", 32'(bram_addr), 32'd0);
        check("async rst kernel_size", 32'(kernel_size), 32'd5);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) words[i] = $urandom;
        do_load(2, 5'b00001, 2, 0, 1, 20, "post reset load");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
